dense_fwd_sched: RTL and testbench
==================================

Name: dense_fwd_sched

Overview:
- Scheduler for the dense forward datapath of the training pipeline.
- Sequences one forward pass: raises the datapath's run, streams weight-memory read addresses in lock-step with the datapath's internal counters, waits for its valid, then drops run and reports completion.
- Also arbitrates the single-port weight memory between the forward pass and the weight-update requester.

Parameters:
- SLICES, 3, number of DATA_N-wide input slices per output row (HID_DIM/DATA_N).
- ROWS, 200, number of output rows (CHAR_NUM).
- ADDR_W, 10, weight memory address width; must satisfy 2^ADDR_W >= SLICES*ROWS.
- TIMEOUT, 632, cycles after run rises before a missing valid is flagged (SLICES*ROWS+32).

Ports:
- clk  in  1  clock; one clock.
- rst  in  1  reset; reset is synchronous and active-high.
- start  in  1  single-cycle request for one forward pass.
- abort  in  1  cancels the current or pending pass.
- busy  out  1  high from accepted start until done/abort/error.
- done  out  1  one-cycle pulse; datapath q is stable and valid.
- err  out  1  sticky timeout flag; cleared by rst or by the next accepted start.
- dense_run  out  1  run to the dense forward datapath.
- dense_valid  in  1  valid from the dense forward datapath.
- upd_req  in  1  weight-update requester wants the memory.
- upd_gnt  out  1  grant to the update requester.
- upd_addr  in  ADDR_W  update write address.
- upd_we  in  1  update write enable.
- mem_addr  out  ADDR_W  weight memory address (1-cycle read latency).
- mem_re  out  1  memory read enable.
- mem_we  out  1  memory write enable.

Behaviour:
- Reset: state IDLE, all outputs 0, pending flag 0, counters 0. Reset mid-pass forces IDLE next cycle with no done pulse.
- States: IDLE, UPD, RUN, WAIT, DONE.
- IDLE:
  - start (or pending set) -> RUN. This has priority over upd_req when both arrive in the same cycle.
  - else upd_req -> UPD.
- UPD:
  - upd_gnt=1; mem_addr=upd_addr, mem_we=upd_we, mem_re=0.
  - start arriving here sets pending (busy=1).
  - upd_req low -> IDLE, upd_gnt drops the same cycle the state leaves.
- RUN:
  - dense_run=1, mem_re=1, mem_addr=addr counter. The counter starts at 0 on the first RUN cycle and increments by 1 per cycle.
  - Address k is presented on the cycle the datapath's counter equals (k mod SLICES, k div SLICES), so read data returns aligned to its slice index.
  - After address SLICES*ROWS-1 -> WAIT. mem_re=0 and mem_addr holds the last value.
- WAIT: dense_run stays 1; on dense_valid=1 -> DONE.
- DONE:
  - dense_run=0, done=1 for exactly one cycle, busy=0 the following cycle, then IDLE.
  - dense_valid being high in the same cycle as run falls is ignored.
- Timeout: a cycle counter runs from the first RUN cycle. Reaching TIMEOUT in RUN/WAIT without valid -> err=1, dense_run=0, IDLE, no done.
- abort:
  - In RUN/WAIT: dense_run=0 next cycle, IDLE, no done.
  - In UPD: clears pending only; the grant is untouched.
  - In IDLE: no effect.
- start while RUN/WAIT/DONE: ignored (no queueing). start while pending already set: no extra effect.
- upd_req is never granted while dense_run=1. Requests wait until IDLE.
- Nominal latency: start at cycle 0 -> dense_run rises at cycle 1, last address at cycle SLICES*ROWS, valid expected at SLICES*ROWS+5, done one cycle after valid is sampled.
- mem_we is asserted only in UPD. mem_re and mem_we are never both 1.

Test Plan:
- Nominal pass (SLICES=3, ROWS=200): start pulse, valid model at run+604 -> addresses 0..599 consecutive with mem_re=1; done pulses once one cycle after valid; dense_run drops with done; busy low after.
- Arbitration: upd_req held 10 cycles from IDLE, start at grant cycle 3 -> upd_gnt 10 cycles with mem_we pass-through; dense_run rises the cycle after upd_req drops; no overlap of upd_gnt and dense_run.
- Simultaneous start and upd_req in IDLE -> RUN wins; upd_gnt=0 until the cycle after done, then granted.
- Abort at address 137 -> dense_run=0 next cycle, no done, busy=0; a new start restarts at address 0.
- Timeout: valid never asserted -> err=1 at run+632, dense_run=0, IDLE; next start clears err and the pass completes normally.
- Reset asserted in WAIT -> all outputs 0 next cycle; a start after reset completes normally with done.

Source files
------------

// File: rtl/dense_fwd_sched.sv
// Forward-pass scheduler for the dense datapath: sequences run/read-address streaming,
// waits for the datapath's valid, and arbitrates the weight memory with the update requester.
module dense_fwd_sched #(
    parameter int SLICES  = 3,
    parameter int ROWS    = 200,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 632
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              dense_run_o,
    input  logic              dense_valid_i,
    input  logic              upd_req_i,
    output logic              upd_gnt_o,
    input  logic [ADDR_W-1:0] upd_addr_i,
    input  logic              upd_we_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_re_o,
    output logic              mem_we_o
);

    localparam int SL_W = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int RW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int TC_W = $clog2(TIMEOUT + 1);

    localparam logic [SL_W-1:0] LAST_SLICE = SL_W'(SLICES - 1);
    localparam logic [RW_W-1:0] LAST_ROW   = RW_W'(ROWS - 1);
    localparam logic [TC_W-1:0] TC_LIMIT   = TC_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_UPD  = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              pending_q, pending_d;
    logic              err_q, err_d;
    logic              run_q, run_d;
    logic              re_q, re_d;
    logic              gnt_q, gnt_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SL_W-1:0]   slice_q, slice_d;
    logic [RW_W-1:0]   row_q, row_d;
    logic [TC_W-1:0]   tcnt_q, tcnt_d;

    logic              err_set_s;
    logic              err_clr_s;
    logic              upd_pend_s;
    logic              last_s;
    logic              tc_hit_s;
    logic              enter_run_s;
    logic              active_s;

    // The address counter mirrors the datapath's (slice,row) counter so the
    // last read is issued exactly on its final slice of the final row.
    assign last_s   = (slice_q == LAST_SLICE) && (row_q == LAST_ROW);
    assign tc_hit_s = (tcnt_q == TC_LIMIT);
    assign active_s = (state_q == S_RUN) || (state_q == S_WAIT);

    // Pending start captured while the update owner holds the memory.
    always_comb begin
        if (abort_i) begin
            upd_pend_s = 1'b0;
        end else if (start_i) begin
            upd_pend_s = 1'b1;
        end else begin
            upd_pend_s = pending_q;
        end
    end

    // Next-state logic; abort outranks valid and timeout, valid outranks timeout.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        err_set_s = 1'b0;
        err_clr_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                pending_d = 1'b0;
                if (start_i || pending_q) begin
                    state_d   = S_RUN;
                    err_clr_s = start_i;
                end else if (upd_req_i) begin
                    state_d = S_UPD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_UPD: begin
                err_clr_s = start_i && !abort_i;
                if (!upd_req_i && upd_pend_s) begin
                    state_d   = S_RUN;
                    pending_d = 1'b0;
                end else if (!upd_req_i) begin
                    state_d   = S_IDLE;
                    pending_d = 1'b0;
                end else begin
                    state_d   = S_UPD;
                    pending_d = upd_pend_s;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (tc_hit_s) begin
                    state_d   = S_IDLE;
                    err_set_s = 1'b1;
                end else if (last_s) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_WAIT: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (dense_valid_i) begin
                    state_d = S_DONE;
                end else if (tc_hit_s) begin
                    state_d   = S_IDLE;
                    err_set_s = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                if (upd_req_i) begin
                    state_d = S_UPD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                pending_d = 1'b0;
            end
        endcase
    end

    // Address, slice/row and timeout counters; all restart on entry to RUN.
    always_comb begin
        addr_d      = addr_q;
        slice_d     = slice_q;
        row_d       = row_q;
        tcnt_d      = tcnt_q;
        enter_run_s = (state_d == S_RUN) && (state_q != S_RUN);
        if (enter_run_s) begin
            addr_d  = {ADDR_W{1'b0}};
            slice_d = {SL_W{1'b0}};
            row_d   = {RW_W{1'b0}};
            tcnt_d  = {TC_W{1'b0}};
        end else begin
            if ((state_q == S_RUN) && (state_d == S_RUN)) begin
                addr_d = addr_q + ADDR_W'(1);
                if (slice_q == LAST_SLICE) begin
                    slice_d = {SL_W{1'b0}};
                    row_d   = row_q + RW_W'(1);
                end else begin
                    slice_d = slice_q + SL_W'(1);
                    row_d   = row_q;
                end
            end else begin
                addr_d  = addr_q;
                slice_d = slice_q;
                row_d   = row_q;
            end
            if (active_s) begin
                tcnt_d = tcnt_q + TC_W'(1);
            end else begin
                tcnt_d = tcnt_q;
            end
        end
    end

    // Output flops are decoded from the next state so they line up with it.
    always_comb begin
        run_d  = (state_d == S_RUN) || (state_d == S_WAIT);
        re_d   = (state_d == S_RUN);
        gnt_d  = (state_d == S_UPD);
        done_d = (state_d == S_DONE);
        busy_d = run_d || done_d || pending_d;
        if (err_set_s) begin
            err_d = 1'b1;
        end else if (err_clr_s) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
            run_q     <= 1'b0;
            re_q      <= 1'b0;
            gnt_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            slice_q   <= {SL_W{1'b0}};
            row_q     <= {RW_W{1'b0}};
            tcnt_q    <= {TC_W{1'b0}};
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            run_q     <= run_d;
            re_q      <= re_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            addr_q    <= addr_d;
            slice_q   <= slice_d;
            row_q     <= row_d;
            tcnt_q    <= tcnt_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign dense_run_o = run_q;
    assign upd_gnt_o   = gnt_q;
    assign mem_re_o    = re_q;
    // While granted, the update port drives the memory address and write strobe directly.
    assign mem_addr_o  = gnt_q ? upd_addr_i : addr_q;
    assign mem_we_o    = gnt_q & upd_we_i;

endmodule

// File: tb/tb_dense_fwd_sched.sv
// Directed bench for dense_fwd_sched: nominal pass, arbitration, abort, timeout and reset cases.
module tb_dense_fwd_sched;

    localparam int SLICES  = 3;
    localparam int ROWS    = 200;
    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 632;
    localparam int TOTAL   = SLICES * ROWS;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic              abort_i;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic              dense_run_o;
    logic              dense_valid_i;
    logic              upd_req_i;
    logic              upd_gnt_o;
    logic [ADDR_W-1:0] upd_addr_i;
    logic              upd_we_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_re_o;
    logic              mem_we_o;

    int checks = 0;
    int errors = 0;

    dense_fwd_sched #(
        .SLICES (SLICES),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .dense_run_o  (dense_run_o),
        .dense_valid_i(dense_valid_i),
        .upd_req_i    (upd_req_i),
        .upd_gnt_o    (upd_gnt_o),
        .upd_addr_i   (upd_addr_i),
        .upd_we_i     (upd_we_i),
        .mem_addr_o   (mem_addr_o),
        .mem_re_o     (mem_re_o),
        .mem_we_o     (mem_we_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Entered on the first RUN cycle; walks the pass to the cycle after done.
    task automatic finish_pass(input string tag);
        int bad;
        bad = 0;
        for (int k = 0; k < TOTAL; k++) begin
            if (mem_addr_o !== 10'(k) || mem_re_o !== 1'b1 || dense_run_o !== 1'b1 ||
                busy_o !== 1'b1 || done_o !== 1'b0 || err_o !== 1'b0 ||
                upd_gnt_o !== 1'b0 || mem_we_o !== 1'b0) bad++;
            tick();
        end
        chk({tag, "_addr_seq"}, bad, 0);
        bad = 0;
        for (int w = 0; w < 4; w++) begin
            if (mem_re_o !== 1'b0 || mem_addr_o !== 10'(TOTAL - 1) || dense_run_o !== 1'b1 ||
                done_o !== 1'b0 || busy_o !== 1'b1 || upd_gnt_o !== 1'b0) bad++;
            tick();
        end
        chk({tag, "_wait"}, bad, 0);
        dense_valid_i = 1'b1;
        tick();
        chk({tag, "_done"}, done_o, 1);
        chk({tag, "_run_drop"}, dense_run_o, 0);
        chk({tag, "_busy_in_done"}, busy_o, 1);
        chk({tag, "_gnt_in_done"}, upd_gnt_o, 0);
        tick();
        dense_valid_i = 1'b0;
        chk({tag, "_done_once"}, done_o, 0);
        chk({tag, "_busy_after"}, busy_o, 0);
        chk({tag, "_run_after"}, dense_run_o, 0);
    endtask

    task automatic do_pass(input string tag);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        finish_pass(tag);
    endtask

    initial begin
        int bad;
        logic we_v;
        rst_i         = 1'b1;
        start_i       = 1'b0;
        abort_i       = 1'b0;
        dense_valid_i = 1'b0;
        upd_req_i     = 1'b0;
        upd_addr_i    = 10'd0;
        upd_we_i      = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_run", dense_run_o, 0);
        chk("rst_gnt", upd_gnt_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_re", mem_re_o, 0);
        chk("rst_we", mem_we_o, 0);
        rst_i = 1'b0;
        tick();
        chk("idle_run", dense_run_o, 0);

        // Nominal pass.
        do_pass("nominal");

        // Simultaneous start and upd_req: RUN wins, grant follows done.
        start_i   = 1'b1;
        upd_req_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("simul_no_gnt", upd_gnt_o, 0);
        finish_pass("simul");
        chk("simul_gnt_after_done", upd_gnt_o, 1);
        upd_req_i = 1'b0;
        tick();
        chk("simul_gnt_release", upd_gnt_o, 0);

        // Arbitration: update owns memory 10 cycles, start queued at grant cycle 3.
        upd_req_i = 1'b1;
        tick();
        bad = 0;
        for (int i = 1; i <= 10; i++) begin
            we_v       = ((i % 2) == 1);
            upd_addr_i = 10'(100 + i);
            upd_we_i   = we_v;
            start_i    = (i == 3);
            upd_req_i  = (i < 10);
            #1;
            if (upd_gnt_o !== 1'b1 || mem_addr_o !== 10'(100 + i) || mem_we_o !== we_v ||
                mem_re_o !== 1'b0 || dense_run_o !== 1'b0 || busy_o !== (i >= 4)) bad++;
            tick();
        end
        chk("arb_grant_window", bad, 0);
        start_i  = 1'b0;
        upd_we_i = 1'b0;
        chk("arb_run_after_req_drop", dense_run_o, 1);
        chk("arb_gnt_dropped", upd_gnt_o, 0);
        finish_pass("arb");

        // Abort inside UPD cancels only the pending pass.
        upd_req_i = 1'b1;
        tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("updabort_pending_busy", busy_o, 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("updabort_busy_clr", busy_o, 0);
        chk("updabort_gnt_kept", upd_gnt_o, 1);
        upd_req_i = 1'b0;
        tick();
        chk("updabort_no_run", dense_run_o, 0);
        chk("updabort_gnt_off", upd_gnt_o, 0);

        // Abort at address 137.
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (137) tick();
        chk("abort_at_addr", mem_addr_o, 137);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_run", dense_run_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_re", mem_re_o, 0);
        bad = 0;
        dense_valid_i = 1'b1;
        for (int j = 0; j < 5; j++) begin
            if (done_o !== 1'b0 || dense_run_o !== 1'b0) bad++;
            tick();
        end
        dense_valid_i = 1'b0;
        chk("abort_no_done", bad, 0);
        do_pass("restart");

        // Timeout: valid never arrives.
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (TIMEOUT - 1) tick();
        chk("tmo_not_yet_err", err_o, 0);
        chk("tmo_not_yet_run", dense_run_o, 1);
        tick();
        chk("tmo_err", err_o, 1);
        chk("tmo_run", dense_run_o, 0);
        chk("tmo_busy", busy_o, 0);
        chk("tmo_no_done", done_o, 0);
        tick();
        chk("tmo_err_sticky", err_o, 1);
        do_pass("after_tmo");

        // Synchronous reset while waiting for valid.
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (TOTAL + 2) tick();
        chk("wrst_in_wait", dense_run_o, 1);
        rst_i = 1'b1;
        tick();
        chk("wrst_run", dense_run_o, 0);
        chk("wrst_busy", busy_o, 0);
        chk("wrst_done", done_o, 0);
        chk("wrst_addr", mem_addr_o, 0);
        chk("wrst_re", mem_re_o, 0);
        rst_i         = 1'b0;
        dense_valid_i = 1'b1;
        tick();
        dense_valid_i = 1'b0;
        chk("wrst_no_done", done_o, 0);
        do_pass("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
